// File: rtl/narrow_16b_8b.sv
// narrow_16b_8b: narrows 16-bit words to bytes, truncating or splitting per word
module narrow_16b_8b #(
   parameter bit HIGH_FIRST = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic        mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_last,
   output logic        ovf,
   output logic [7:0]  ovf_count
);
   typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;
   state_t state, state_nxt;
   logic [15:0] held;
   logic split;
   logic [7:0] first_byte, second_byte;
   logic in_xfer, out_xfer;
   // byte selection, handshakes and next-state decode from held word and state
   always_comb begin
      out_valid   = state != IDLE;
      out_last    = state == SECOND || (state == FIRST && !split);
      ovf         = state == FIRST && !split && |held[15:8];
      first_byte  = (split && HIGH_FIRST) ? held[15:8] : held[7:0];
      second_byte = HIGH_FIRST ? held[7:0] : held[15:8];
      out_data    = state == FIRST ? first_byte : state == SECOND ? second_byte : 8'h00;
      in_ready    = state == IDLE || (out_valid && out_ready && out_last);
      in_xfer     = in_valid && in_ready;
      out_xfer    = out_valid && out_ready;
      state_nxt   = in_xfer ? FIRST : out_xfer ? (out_last ? IDLE : SECOND) : state;
   end
   // state, holding register and saturating overflow counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         held      <= 16'h0000;
         split     <= 1'b0;
         ovf_count <= 8'h00;
      end else begin
         state <= state_nxt;
         if (in_xfer) begin
            held  <= in_data;
            split <= mode;
         end
         if (out_xfer && ovf && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
      end
   end
endmodule

// File: doc/narrow_16b_8b.md
NARROW_16B_8B -- requirements
Module: narrow_16b_8b

Interface
REQ-001 Parameter: HIGH_FIRST, default 0, byte order in split mode (0 = low byte first, 1 = high byte first).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: in_valid  input  1  producer has a word on in_data.
REQ-006 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-007 Port: in_data  input  16  word to narrow.
REQ-008 Port: mode  input  1  0 = truncate (one byte out), 1 = split (two bytes out); sampled with in_data.
REQ-009 Port: out_valid  output  1  out_data holds a byte.
REQ-010 Port: out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 Port: out_data  output  8  byte output.
REQ-012 Port: out_last  output  1  current byte is the final byte of its word.
REQ-013 Port: ovf  output  1  truncate-mode byte lost nonzero upper bits.
REQ-014 Port: ovf_count  output  8  saturating count of ovf bytes delivered.

Function
REQ-015 An input transfer SHALL occur when in_valid and in_ready are both high at a rising edge; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-016 The FSM SHALL have three states: IDLE (no byte held), FIRST (first or only byte presented), SECOND (second split byte presented).
REQ-017 in_ready SHALL be high in IDLE, and also in FIRST or SECOND during a cycle in which out_valid, out_ready and out_last are all high (combinational path from out_ready).
REQ-018 On an input transfer, the block SHALL latch in_data and mode into a 16-bit holding register and a mode flag, then enter FIRST.
REQ-019 In FIRST with truncate mode: out_data = held[7:0]; out_last = 1; ovf = 1 if held[15:8] is nonzero, else 0.
REQ-020 In FIRST with split mode: out_data = held[7:0] when HIGH_FIRST=0, held[15:8] when HIGH_FIRST=1; out_last = 0; ovf = 0.
REQ-021 In SECOND: out_data = the byte not sent in FIRST; out_last = 1; ovf = 0.
REQ-022 Transitions: FIRST->SECOND on an output transfer with out_last=0. FIRST or SECOND -> FIRST on an output transfer with out_last=1 and a simultaneous input transfer. FIRST or SECOND -> IDLE on an output transfer with out_last=1 and no input transfer. Any non-IDLE state holds when there is no output transfer.
REQ-023 out_valid SHALL be high exactly when the state is not IDLE.
REQ-024 out_data, out_last and ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 Latency: the first byte appears on the cycle after the input transfer.
REQ-026 Throughput: truncate mode sustains one word per cycle; split mode sustains one word per two cycles.
REQ-027 ovf_count SHALL increment by 1 on each output transfer with ovf=1, and SHALL saturate at 8'hFF.
REQ-028 in_data and mode SHALL be ignored when no input transfer occurs; a mode change mid-word SHALL NOT affect the held word.
REQ-029 The output registers SHALL be driven only from the holding register and the FSM, with no combinational path from in_data to out_data.

Reset
REQ-030 While rst_n=0: state=IDLE, holding register=16'h0000, out_valid=0, out_data=8'h00, out_last=0, ovf=0, ovf_count=8'h00, in_ready=1 (IDLE).
REQ-031 When reset is asserted mid-word, the block SHALL discard the word immediately with no partial byte emitted after release.
REQ-032 The first input transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-033 Truncate, HIGH_FIRST=0, out_ready=1, words 16'h0042 then 16'h1234 back-to-back -> bytes 8'h42 (last=1, ovf=0) then 8'h34 (last=1, ovf=1); ovf_count=1; in_ready stays 1.
REQ-034 Split, HIGH_FIRST=0, word 16'hABCD -> 8'hCD (last=0) then 8'hAB (last=1); in_ready=0 during the 8'hCD cycle.
REQ-035 Split, HIGH_FIRST=1, word 16'hABCD, out_ready held 0 for 3 cycles -> 8'hAB held stable for 4 cycles, then 8'hCD; no extra bytes.
REQ-036 Truncate, 300 words of 16'hFF00 -> 300 bytes of 8'h00 with ovf=1; ovf_count saturates at 8'hFF.
REQ-037 Split word 16'h5A5A, rst_n pulsed low while in SECOND -> out_valid=0 immediately; ovf_count=0; no 8'h5A byte after release.
REQ-038 Final byte accepted while the next word is offered (split then truncate 16'h0077) -> 8'h77 presented on the next cycle with no bubble.
